// File: rtl/ava_pkg.sv
// Shared types and default geometry for the AVA raster scan controller.
package ava_pkg;

  localparam int X_RES           = 640;
  localparam int Y_RES           = 480;
  localparam int VRAM_ADDR_WIDTH = 19;

  localparam int COORD_X_W = $clog2(X_RES);
  localparam int COORD_Y_W = $clog2(Y_RES);

  typedef struct packed {
    logic [COORD_Y_W-1:0] y;
    logic [COORD_X_W-1:0] x;
  } coords_t;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } scan_state_t;

endpackage

// File: rtl/ava_scan_walker.sv
// VRAM address walker: turns a stream of display-pixel steps into framebuffer
// addresses with power-of-two pixel replication; scale and base latch per frame.
module ava_scan_walker
  import ava_pkg::*;
#(
  parameter  int H_RES          = X_RES,
  parameter  int V_RES          = Y_RES,
  parameter  int SCALE_LOG2_MAX = 2,
  parameter  int ADDR_W         = VRAM_ADDR_WIDTH,
  localparam int SW             = $clog2(SCALE_LOG2_MAX + 1)
) (
  input  logic              clk,
  input  logic              load,
  input  logic              step,
  input  logic [SW-1:0]     scale_log2,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr
);

  localparam int SUBW = (SCALE_LOG2_MAX > 0) ? SCALE_LOG2_MAX : 1;
  // One extra bit so the full line/frame size itself is representable.
  localparam int AXW  = $clog2(H_RES + 1);
  localparam int AYW  = $clog2(V_RES + 1);

  localparam logic [AXW-1:0] H_FULL    = AXW'(H_RES);
  localparam logic [AYW-1:0] V_FULL    = AYW'(V_RES);
  localparam logic [SW-1:0]  SCALE_MAX = SW'(SCALE_LOG2_MAX);

  logic [SW-1:0]     scale_r;
  logic [SUBW-1:0]   sx_r;
  logic [SUBW-1:0]   sy_r;
  logic [AXW-1:0]    ax_r;
  logic [AYW-1:0]    ay_r;
  logic [ADDR_W-1:0] row_base_r;
  logic [ADDR_W-1:0] addr_r;

  logic [SUBW-1:0]   sub_max_s;
  logic [AXW-1:0]    cols_s;
  logic [AYW-1:0]    rows_s;
  logic [ADDR_W-1:0] row_step_s;
  logic [SW-1:0]     scale_in_s;
  logic              x_wrap_s;
  logic              y_wrap_s;
  logic              line_wrap_s;
  logic              frame_wrap_s;

  // Wrap conditions of the replication and VRAM counters for the current scale.
  always_comb begin
    sub_max_s    = ~({SUBW{1'b1}} << scale_r);
    cols_s       = H_FULL >> scale_r;
    rows_s       = V_FULL >> scale_r;
    row_step_s   = ADDR_W'(cols_s);
    x_wrap_s     = (sx_r == sub_max_s);
    y_wrap_s     = (sy_r == sub_max_s);
    line_wrap_s  = x_wrap_s && (ax_r == cols_s - AXW'(1));
    frame_wrap_s = line_wrap_s && y_wrap_s && (ay_r == rows_s - AYW'(1));
    scale_in_s   = (scale_log2 > SCALE_MAX) ? SCALE_MAX : scale_log2;
  end

  // Walker counters; a line end without a row wrap re-reads the same VRAM row.
  always_ff @(posedge clk) begin
    if (load || (step && frame_wrap_s)) begin
      scale_r    <= scale_in_s;
      sx_r       <= '0;
      sy_r       <= '0;
      ax_r       <= '0;
      ay_r       <= '0;
      row_base_r <= base_addr;
      addr_r     <= base_addr;
    end else if (step) begin
      if (line_wrap_s) begin
        sx_r <= '0;
        ax_r <= '0;
        if (y_wrap_s) begin
          sy_r       <= '0;
          ay_r       <= ay_r + AYW'(1);
          row_base_r <= row_base_r + row_step_s;
          addr_r     <= row_base_r + row_step_s;
        end else begin
          sy_r   <= sy_r + SUBW'(1);
          addr_r <= row_base_r;
        end
      end else if (x_wrap_s) begin
        sx_r   <= '0;
        ax_r   <= ax_r + AXW'(1);
        addr_r <= addr_r + ADDR_W'(1);
      end else begin
        sx_r <= sx_r + SUBW'(1);
      end
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/ava_scan_ctrl.sv
// Raster scan controller: display coords plus a VRAM address running VRAM_LATENCY
// pixels ahead. Define AVA_SCAN_STATS_EN to add frame_cnt/stall_cnt outputs.
module ava_scan_ctrl
  import ava_pkg::*;
#(
  parameter  int H_RES          = X_RES,
  parameter  int V_RES          = Y_RES,
  parameter  int SCALE_LOG2_MAX = 2,
  parameter  int VRAM_LATENCY   = 1,
  parameter  int ADDR_W         = VRAM_ADDR_WIDTH,
  localparam int SW             = $clog2(SCALE_LOG2_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_fifo_full,
  input  logic [SW-1:0]     scale_log2,
  input  logic [ADDR_W-1:0] base_addr,
  output coords_t           coords,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              line_end,
  output logic              vblank
`ifdef AVA_SCAN_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [COORD_X_W-1:0] X_LAST = COORD_X_W'(H_RES - 1);
  localparam logic [COORD_Y_W-1:0] Y_LAST = COORD_Y_W'(V_RES - 1);

  scan_state_t state_r;
  logic [2:0]  prime_cnt_r;
  coords_t     coords_r;
  logic        line_end_r;
  logic        vblank_r;

  coords_t     coords_nxt_s;
  logic        x_last_s;
  logic        y_last_s;
  logic        advance_s;
  logic        step_s;

  // Next coordinate and step enables; PRIME steps the walker even while stalled.
  always_comb begin
    x_last_s     = (coords_r.x == X_LAST);
    y_last_s     = (coords_r.y == Y_LAST);
    advance_s    = (state_r == RUN) && !pixel_fifo_full;
    step_s       = (state_r == PRIME) || advance_s;
    coords_nxt_s = coords_r;
    if (x_last_s) begin
      coords_nxt_s.x = '0;
      coords_nxt_s.y = y_last_s ? '0 : coords_r.y + COORD_Y_W'(1);
    end else begin
      coords_nxt_s.x = coords_r.x + COORD_X_W'(1);
    end
  end

  // Scan FSM with registered coordinate and strobe outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= (VRAM_LATENCY == 0) ? RUN : PRIME;
      prime_cnt_r <= 3'(VRAM_LATENCY);
      coords_r    <= '0;
      line_end_r  <= 1'b0;
      vblank_r    <= 1'b0;
    end else begin
      case (state_r)
        PRIME: begin
          prime_cnt_r <= prime_cnt_r - 3'd1;
          if (prime_cnt_r == 3'd1) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (advance_s) begin
            coords_r   <= coords_nxt_s;
            line_end_r <= (coords_nxt_s.x == X_LAST);
            vblank_r   <= (coords_nxt_s.x == X_LAST) && (coords_nxt_s.y == Y_LAST);
          end
        end
        default: begin
          state_r <= PRIME;
        end
      endcase
    end
  end

  ava_scan_walker #(
    .H_RES          (H_RES),
    .V_RES          (V_RES),
    .SCALE_LOG2_MAX (SCALE_LOG2_MAX),
    .ADDR_W         (ADDR_W)
  ) u_walker (
    .clk        (clk),
    .load       (reset),
    .step       (step_s),
    .scale_log2 (scale_log2),
    .base_addr  (base_addr),
    .addr       (vram_addr)
  );

  assign coords   = coords_r;
  assign line_end = line_end_r;
  assign vblank   = vblank_r;

`ifdef AVA_SCAN_STATS_EN
  logic [15:0] frame_cnt_r;
  logic [31:0] stall_cnt_r;

  // Saturating frame and stall counters, active only in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_r <= 16'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (advance_s && x_last_s && y_last_s && (frame_cnt_r != 16'hFFFF)) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if ((state_r == RUN) && pixel_fifo_full && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/ava_scan_ctrl.md
Name: ava_scan_ctrl

Overview:
Parametrised raster scan controller for the AVA video path. It generates display-space pixel coordinates for the pixel pipeline and a VRAM read address that runs VRAM_LATENCY pixels ahead of them. Both stall while the pixel FIFO is full. Adds over the fixed-resolution controller: runtime power-of-two pixel scaling, a relocatable framebuffer base, arbitrary VRAM latency, and a line-end strobe.

Parameters:
- H_RES, 640, display pixels per line; must be divisible by 2^SCALE_LOG2_MAX.
- V_RES, 480, display lines per frame; must be divisible by 2^SCALE_LOG2_MAX.
- SCALE_LOG2_MAX, 2, maximum supported log2 pixel-replication factor.
- VRAM_LATENCY, 1, VRAM read latency in cycles (0..7); sets the address lookahead.
- ADDR_W, 19, VRAM address width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- pixel_fifo_full, in, 1, stall request from the pixel FIFO.
- scale_log2, in, $clog2(SCALE_LOG2_MAX+1), requested scale; display pixel = VRAM pixel replicated 2^s times in x and y.
- base_addr, in, ADDR_W, framebuffer base address in VRAM.
- coords, out, coords_t, display-space x,y.
- vram_addr, out, ADDR_W, VRAM read address.
- line_end, out, 1, high while coords.x == H_RES-1.
- vblank, out, 1, high while coords == (H_RES-1, V_RES-1) and state is RUN.

Behaviour:
- Reset values: coords=(0,0); vram_addr=base_addr; state=PRIME with prime_cnt=VRAM_LATENCY (state=RUN if VRAM_LATENCY=0). scale_log2 and base_addr are latched into the walker.
- FSM PRIME:
  - Address walker advances one step per cycle, regardless of pixel_fifo_full.
  - coords hold at (0,0).
  - prime_cnt decrements; when it reaches 0 and the walker has advanced, state goes to RUN.
  - PRIME lasts exactly VRAM_LATENCY cycles.
- FSM RUN:
  - When pixel_fifo_full=0, coords and walker both advance one step per cycle.
  - When pixel_fifo_full=1, everything holds, including line_end and vblank.
  - RUN has no exit except reset.
- Invariant in RUN: vram_addr = addr_of(step index of coords + VRAM_LATENCY), taken modulo the frame.
- Coord counter: x increments; at H_RES-1, x wraps to 0 and y increments; at (H_RES-1, V_RES-1), both wrap to (0,0).
- Walker state: sub-pixel counters sx, sy (0..2^s-1), VRAM column ax, row_base; vram_addr = row_base + ax.
  - x step: sx increments; at 2^s-1, sx=0 and ax increments.
  - Line end (display column H_RES-1): ax=0, sx=0. If sy==2^s-1 then sy=0 and row_base += H_RES>>s; otherwise sy increments and row_base is unchanged, so the row is re-read.
  - Frame end: row_base=base_addr; the walker latches new scale_log2 and base_addr here, so a change takes effect only at the walker's frame wrap. Because the walker leads, it can switch up to VRAM_LATENCY pixels before the coords wrap; this is intended.
- Arithmetic: no multipliers. Address arithmetic is modulo 2^ADDR_W; overflow wraps silently.
- Reset mid-frame: abandons the frame and restarts PRIME on the next cycle; no partial state survives.
- Stall during PRIME is ignored, because the FIFO is empty after reset by construction.

Optional Feature:
- AVA_SCAN_STATS_EN defined: adds outputs frame_cnt[15:0] and stall_cnt[31:0].
  - frame_cnt increments when coords wrap to (0,0) in RUN.
  - stall_cnt increments each RUN cycle with pixel_fifo_full=1.
  - Both reset to 0 and saturate at all-ones.
- Undefined: the ports and logic are absent. Core behaviour is identical either way.

Decomposition:
- ava_pkg holds:
  - coords_t, widened to $clog2(H_RES) / $clog2(V_RES).
  - scan_state_t enum {PRIME, RUN}.
  - Default X_RES, Y_RES, VRAM_ADDR_WIDTH.
- Sub-module ava_scan_walker: sx/sy/ax/row_base counters, the scale/base latch, inputs step and load, output addr. It is instantiated once.

Test Plan:
- VRAM_LATENCY=1, scale 0, base 0, no stall, release reset: cycle 1 vram_addr=1 with coords=(0,0); cycle 2 vram_addr=2 with coords=(1,0); line_end high at coords.x=639.
- VRAM_LATENCY=3, base 0x100: vram_addr steps 0x100, 0x101, 0x102, 0x103 over PRIME while coords hold at (0,0); RUN then keeps addr = index+3+0x100.
- scale_log2=1: display line 0 reads addresses 0,0,1,1,…,319,319; line 1 repeats them; line 2 starts at 320; the last frame address is 76799.
- Toggle pixel_fifo_full every other cycle for a full frame: coords/addr freeze on full cycles; vblank is high exactly at (639,479); the frame takes 2×307200 cycles.
- Change base_addr and scale_log2 mid-frame: no effect until the walker's wrap, then the new base and scale apply; assert reset mid-line and check coords=(0,0) and PRIME re-entered.
- With AVA_SCAN_STATS_EN: 2 frames with 10 stall cycles give frame_cnt=2 and stall_cnt=10.
